fifo_stream_reader: RTL and testbench

//  Read-side consumer for asynchronous_fifo. Runs in the read clock domain.

---
 rtl/fifo_stream_reader.sv | 100 ++++++++++
 tb/tb_fifo_stream_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-domain consumer for asynchronous_fifo: pops FIFO words into a small ring
// buffer and re-presents them as a valid/ready stream, with flush and beat count.
module fifo_stream_reader #(
    parameter int WIDTH      = 8,
    parameter int OBUF_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 read_en,
    input  logic [WIDTH-1:0]     read_data,
    input  logic                 empty,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic                 busy
);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OW = $clog2(OBUF_DEPTH + 1);
    localparam int LW = OW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [OBUF_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [OW-1:0]    occ;
    logic             pending, run_en, pop_out, push;
    logic [LW-1:0]    level;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign pop_out   = out_valid && out_ready;
    assign busy      = (state == FLUSH) || out_valid || pending;
    // Occupancy once this cycle's arriving word and departing beat are settled.
    assign level     = LW'(occ) + LW'(pending) - LW'(pop_out);

    always_comb begin
        state_nxt = state;
        read_en   = 1'b0;
        push      = 1'b0;
        case (state)
            RUN: begin
                // run_en keeps read_en low while reset is held and until its release settles.
                read_en = run_en && !empty && (int'(level) < OBUF_DEPTH);
                push    = pending;
                if (flush) state_nxt = FLUSH;
            end
            FLUSH: begin
                read_en = !empty;
                if (!flush && empty && !pending) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            run_en   <= 1'b0;
            pending  <= 1'b0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_count <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            state   <= state_nxt;
            run_en  <= 1'b1;
            pending <= read_en;
            if (pop_out) rd_count <= rd_count + CNT_WIDTH'(1);
            if (state == RUN && flush) begin
                // Entering FLUSH empties the buffer; a word landing this edge is dropped.
                occ    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= read_data;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (pop_out) rd_ptr <= ptr_inc(rd_ptr);
                occ <= occ + OW'(push) - OW'(pop_out);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (state == RUN && push && !pop_out) |-> (int'(occ) < OBUF_DEPTH));

    a_no_read_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        empty |-> !read_en);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model, scoreboard of written
// words, and a negedge monitor that checks every accepted beat and rd_count.
module tb_fifo_stream_reader;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          read_en;
    logic [W-1:0]  read_data = '0;
    logic          empty = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          flush = 1'b0;
    logic [CW-1:0] rd_count;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];
    bit           prev_stall = 1'b0;
    bit           prev_fl = 1'b0;
    logic [W-1:0] prev_d = '0;

    fifo_stream_reader #(.WIDTH(W), .OBUF_DEPTH(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .read_en(read_en), .read_data(read_data),
        .empty(empty), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .rd_count(rd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic wait_busy_low(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin step(); n++; end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((busy || out_valid || fq.size() != 0) && n < budget) begin step(); n++; end
        chk(nm, {30'd0, busy, out_valid}, 32'd0);
    endtask

    // FIFO model: 1-cycle read latency, empty flag registered at the clock.
    initial forever begin
        @(posedge clk);
        if (read_en && fq.size() != 0) read_data <= fq.pop_front();
        empty <= (fq.size() == 0);
    end

    // Monitor: accepted beats are those with valid&&ready just before the edge.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            prev_stall = 1'b0;
            model_cnt  = 0;
        end else begin
            chk("rd_count", 32'(rd_count), 32'(model_cnt % (1 << CW)));
            if (read_en) chk("read_en_vs_empty", 32'(empty), 32'd0);
            if (prev_stall && !prev_fl) chk("hold_under_stall", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_d});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, no word outstanding", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                model_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_fl    = flush;
            prev_d     = out_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int re_i, ov_i, fa, la, pops, n;

        // Reset values
        #1;
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();

        // 1: streaming with out_ready=1
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) wr(W'(i));
        re_i = -1; ov_i = -1; fa = -1; la = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (read_en && re_i < 0) re_i = c;
            if (out_valid && ov_i < 0) ov_i = c;
            if (out_valid && out_ready) begin
                if (fa < 0) fa = c;
                la = c;
            end
        end
        chk("t1_latency", 32'(ov_i - re_i), 32'd2);
        chk("t1_back_to_back", 32'(la - fa), 32'd7);
        chk("t1_rd_count", 32'(rd_count), 32'd8);
        step();

        // 2: backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(W'(i));
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (read_en) pops++;
        end
        chk("t2_pops", 32'(pops), 32'd2);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_data", 32'(out_data), 32'h01);
        chk("t2_fifo_left", 32'(fq.size()), 32'd2);
        step();
        out_ready = 1'b1;
        wait_idle(50, "t2_drain");
        chk("t2_rd_count", 32'(rd_count), 32'd12);

        // 3: out_ready toggling over 16 words
        for (int i = 0; i < 16; i++) wr(W'(8'h10 + i));
        n = 0;
        while ((busy || out_valid || fq.size() != 0) && n < 100) begin
            out_ready = ~out_ready;
            step();
            n++;
        end
        chk("t3_done", {30'd0, busy, out_valid}, 32'd0);
        chk("t3_rd_count", 32'(rd_count), 32'd12);  // 28 beats mod 16

        // 4: flush with 2 buffered and 3 in the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(W'(8'hA0 + i));
        repeat (4) step();
        chk("t4_pre_valid", 32'(out_valid), 32'd1);
        chk("t4_pre_fifo", 32'(fq.size()), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_valid_cleared", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_busy_low(50, "t4_flush_done");
        chk("t4_fifo_drained", 32'(fq.size()), 32'd0);
        chk("t4_rd_count", 32'(rd_count), 32'd12);
        exp_q.delete();
        out_ready = 1'b1;
        wr(8'hAA);
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        chk("t4_next_word", 32'(out_data), 32'hAA);
        step();
        wait_idle(20, "t4_idle");
        chk("t4_rd_count_after", 32'(rd_count), 32'd13);

        // 5: async reset with one word buffered and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr(W'(8'hB0 + i));
        repeat (3) step();
        chk("t5_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        exp_q = fq;
        #1;
        chk("t5_read_en", 32'(read_en), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_data", 32'(out_data), 32'd0);
        chk("t5_rd_count", 32'(rd_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_fifo_left", 32'(fq.size()), 32'd4);
        @(negedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();
        out_ready = 1'b1;
        wait_idle(50, "t5_drain");
        chk("t5_rd_count_after", 32'(rd_count), 32'd4);

        // Randomized traffic with occasional flushes
        for (int it = 0; it < 1500; it++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) wr(W'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                flush = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    step();
                    out_ready = ($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 1) == 1) wr(W'($urandom));
                end
                flush = 1'b0;
                wait_busy_low(400, "rand_flush_done");
                exp_q.delete();
            end
        end
        step();
        out_ready = 1'b1;
        wait_idle(2000, "rand_drain");
        chk("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
